// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_phy 8N1 serial block.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_W     = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // round(rate * 2^acc_w / clk_freq)
  function automatic int unsigned acc_inc(
    input int unsigned clk_freq,
    input int unsigned rate,
    input int unsigned acc_w
  );
    longint unsigned num;
    num = (64'(rate) << acc_w) + 64'(clk_freq / 2);
    return 32'(num / 64'(clk_freq));
  endfunction

endpackage

// File: rtl/uart_phy_tick.sv
// Enable-gated phase-accumulator tick generator (uart_baud_tick).
// The accumulator is cleared while disabled so a period starts at enable.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 90_000_000,
  parameter int unsigned RATE     = 1_152_000,
  parameter int unsigned ACC_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [ACC_W-1:0] INC =
    ACC_W'(acc_inc(CLK_FREQ, RATE, ACC_W));

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum;

  assign sum    = {1'b0, acc_q} + {1'b0, INC};
  assign acc_d  = en_i ? sum[ACC_W-1:0] : '0;
  assign tick_o = en_i & sum[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/uart_phy.sv
// Full-duplex 8N1 UART PHY: baud-tick TX shifter, oversampled RX.
// Define UART_RX_FILTER_EN for a 3-sample majority filter on rxd.
module uart_phy
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 90_000_000,
  parameter int unsigned BAUD       = 1_152_000,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned ACC_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  input  logic       txd_start,
  input  logic [7:0] txd_data,
  output logic       txd_busy,
  output logic [7:0] rxd_data,
  output logic       rxd_data_ready,
  input  logic       rxd_clear
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST = BIT_W'(DATA_BITS - 1);

  // ---------------- TX ----------------
  tx_state_t      tx_state_q, tx_state_d;
  logic [BIT_W-1:0] tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic           tx_en;
  logic           tx_tick;

  uart_baud_tick #(
    .CLK_FREQ(CLK_FREQ),
    .RATE    (BAUD),
    .ACC_W   (ACC_W)
  ) u_tx_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (tx_en),
    .tick_o(tx_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (txd_start) begin
          tx_data_d  = txd_data;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_bit_q == LAST) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_state_d = TX_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    tx_en    = (tx_state_q != TX_IDLE);
    txd_busy = tx_en;
    unique case (tx_state_q)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_data_q[tx_bit_q];
      default:  txd = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  logic [1:0]       rx_sync_q;
  logic             rx_bit;
  logic             rx_prev_q;
  logic             rx_fall;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0] rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic             rx_brk_q, rx_brk_d;
  logic [DATA_BITS-1:0] rx_data_q;
  logic             rx_rdy_q;
  logic             rx_en;
  logic             rx_tick;
  logic             rx_samp;
  logic             rx_done;

  uart_baud_tick #(
    .CLK_FREQ(CLK_FREQ),
    .RATE    (BAUD * OVERSAMPLE),
    .ACC_W   (ACC_W)
  ) u_rx_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (rx_en),
    .tick_o(rx_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_q <= 2'b11;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rxd};
    end
  end

`ifdef UART_RX_FILTER_EN
  logic [2:0] flt_q;
  logic       flt_en;

  // Free-running while the line is not being sampled so edges are seen.
  assign flt_en = ~rx_en | rx_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      flt_q <= 3'b111;
    end else if (flt_en) begin
      flt_q <= {flt_q[1:0], rx_sync_q[1]};
    end
  end

  assign rx_bit = (flt_q[0] & flt_q[1]) |
                  (flt_q[0] & flt_q[2]) |
                  (flt_q[1] & flt_q[2]);
`else
  assign rx_bit = rx_sync_q[1];
`endif

  assign rx_fall = rx_prev_q & ~rx_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_brk_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_rdy_q   <= 1'b0;
    end else begin
      rx_prev_q  <= rx_bit;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_brk_q   <= rx_brk_d;
      if (rx_done) begin
        rx_data_q <= rx_sh_q;
        rx_rdy_q  <= 1'b1;
      end else if (rxd_clear) begin
        rx_rdy_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_brk_d   = rx_brk_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_samp) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
        end else if (rx_tick) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_samp) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_bit, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else if (rx_tick) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        // After a bad stop bit, hold until the line returns high.
        if (rx_brk_q) begin
          if (rx_bit) begin
            rx_brk_d   = 1'b0;
            rx_state_d = RX_IDLE;
          end
        end else if (rx_samp) begin
          rx_cnt_d = '0;
          if (rx_bit) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_brk_d = 1'b1;
          end
        end else if (rx_tick) begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    rx_en   = (rx_state_q != RX_IDLE) && !rx_brk_q;
    rx_samp = rx_tick &&
              (rx_cnt_q == ((rx_state_q == RX_START) ? HALF : FULL));
    rx_done = rx_samp && (rx_state_q == RX_STOP) && rx_bit;
  end

  assign rxd_data       = rx_data_q;
  assign rxd_data_ready = rx_rdy_q;

endmodule

// File: tb/tb_uart_phy.sv
// Scoreboard bench for uart_phy: TX frame decoder plus RX byte checker.
// Loopback and direct rxd drive; filter case runs with UART_RX_FILTER_EN.
`timescale 1ns/1ps
module tb_uart_phy;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       txd;
  logic       txd_start;
  logic [7:0] txd_data;
  logic       txd_busy;
  logic [7:0] rxd_data;
  logic       rxd_data_ready;
  logic       rxd_clear;

  logic       loop = 1'b0;
  logic       rxd_drv = 1'b1;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  always #5 clk = ~clk;

  assign rxd = loop ? txd : rxd_drv;

  uart_phy dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .txd           (txd),
    .txd_start     (txd_start),
    .txd_data      (txd_data),
    .txd_busy      (txd_busy),
    .rxd_data      (rxd_data),
    .rxd_data_ready(rxd_data_ready),
    .rxd_clear     (rxd_clear)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mid-point of bit i, in cycles from the start edge (78.125 cyc/bit).
  function automatic int cyc_at(input int i);
    return (625 * i + 312) / 8;
  endfunction

  // TX frame decoder
  logic       txd_prev = 1'b1;
  logic [9:0] mf;
  int         mn;
  always begin
    @(negedge clk);
    if (!rst && txd_prev && !txd) begin
      mn = 0;
      for (int i = 0; i < 10; i++) begin
        while (mn < cyc_at(i)) begin
          @(negedge clk);
          mn++;
        end
        mf[i] = txd;
      end
      chk("tx_start", 32'(mf[0]), 0);
      chk("tx_stop", 32'(mf[9]), 1);
      if (tx_exp.size() == 0)
        chk("tx_unexp", tx_exp.size(), 1);
      else
        chk("tx_data", 32'(mf[8:1]), 32'(tx_exp.pop_front()));
    end
    txd_prev = txd;
  end

  // RX byte checker
  logic rdy_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && rxd_data_ready && !rdy_prev) begin
      if (rx_exp.size() == 0)
        chk("rx_unexp", rx_exp.size(), 1);
      else
        chk("rx_data", 32'(rxd_data), 32'(rx_exp.pop_front()));
    end
    rdy_prev = rxd_data_ready;
  end

  task automatic rx_ack(input string tag);
    chk({tag, "_rdy"}, 32'(rxd_data_ready), 1);
    rxd_clear = 1'b1;
    @(negedge clk);
    rxd_clear = 1'b0;
    chk({tag, "_clr"}, 32'(rxd_data_ready), 0);
  endtask

  task automatic wait_idle(input string tag, output int c);
    c = 1;
    while (txd_busy && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, 32'(txd_busy), 0);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    int c;
    tx_exp.push_back(b);
    rx_exp.push_back(b);
    txd_data  = b;
    txd_start = 1'b1;
    @(negedge clk);
    txd_start = 1'b0;
    chk("busy_on", 32'(txd_busy), 1);
    wait_idle("tx", c);
    chk("busy_len", 32'((c - 1) >= 776 && (c - 1) <= 786), 1);
    repeat (20) @(negedge clk);
    rx_ack("lb");
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int gi);
    logic [9:0] f;
    int n;
    f = {stop, b, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      while (n < (625 * (i + 1)) / 8) begin
        if (i == gi && n >= cyc_at(i) - 2 && n <= cyc_at(i) + 2)
          rxd_drv = ~f[i];
        else
          rxd_drv = f[i];
        @(negedge clk);
        n++;
      end
    end
    rxd_drv = 1'b1;
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst       = 1'b1;
    txd_start = 1'b0;
    txd_data  = 8'h00;
    rxd_clear = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(txd_busy), 0);
    chk("rst_rdy", 32'(rxd_data_ready), 0);
    chk("rst_data", 32'(rxd_data), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    loop = 1'b1;
    tx_byte(8'hA5);
    tx_byte(8'h00);
    tx_byte(8'hFF);
    tx_byte(8'h3C);

    // start while busy must be dropped
    tx_exp.push_back(8'hC3);
    rx_exp.push_back(8'hC3);
    txd_data  = 8'hC3;
    txd_start = 1'b1;
    @(negedge clk);
    txd_start = 1'b0;
    repeat (300) @(negedge clk);
    txd_data  = 8'h55;
    txd_start = 1'b1;
    @(negedge clk);
    txd_start = 1'b0;
    wait_idle("ign", c);
    repeat (20) @(negedge clk);
    rx_ack("ign");
    repeat (900) @(negedge clk);
    chk("ign_idle", 32'(txd_busy), 0);
    chk("ign_txq", tx_exp.size(), 0);

    // framing error then a good byte
    loop = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h42, 1'b0, -1);
    repeat (40) @(negedge clk);
    chk("fe_rdy", 32'(rxd_data_ready), 0);
    chk("fe_data", 32'(rxd_data), 32'h C3);
    rx_exp.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    repeat (20) @(negedge clk);
    rx_ack("fe_ok");

    // short low glitch on idle line
    rxd_drv = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("gl_rdy", 32'(rxd_data_ready), 0);
    chk("gl_data", 32'(rxd_data), 32'h81);

`ifdef UART_RX_FILTER_EN
    rx_exp.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 4);
    repeat (20) @(negedge clk);
    rx_ack("flt");
`endif

    repeat (20) @(negedge clk);
    chk("end_txq", tx_exp.size(), 0);
    chk("end_rxq", rx_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
